// File: rtl/sc_statemachine_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sc_statemachine_ctrl_pkg
//  Description : Shared state codes and field widths for the game-datapath
//                control FSM and its helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package sc_statemachine_ctrl_pkg;

    localparam int unsigned c_STATE_W = 4;  // width of the debug state code
    localparam int unsigned c_SPEED_W = 2;  // width of the tick rate select

    // Codes are visible on state_Out, so the numbering is fixed.
    typedef enum logic [c_STATE_W-1:0] {
        RESET_0 = 4'd0,
        START_0 = 4'd1,
        IDLE_0  = 4'd2,
        INIT_0  = 4'd3,
        HOLD_0  = 4'd4,
        CHECK_0 = 4'd5,
        SHIFT_0 = 4'd6,
        COUNT_0 = 4'd7,
        PAUSE_0 = 4'd8
    } state_t;

endpackage
`default_nettype wire

// File: rtl/sc_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sc_rr_arbiter
//  Description : Combinational round-robin picker. Grants the first active-low
//                request at index >= i_ptr, wrapping back to index 0.
//  Ports       : i_req_InLow  N-bit active-low request vector
//                i_ptr        search start index (always < N)
//                o_grant      granted index (0 when nothing requested)
//                o_valid      high when at least one request is low
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_rr_arbiter
    import sc_statemachine_ctrl_pkg::*;
#(
    parameter int N     = 4,
    parameter int PTR_W = 2
) (
    input  logic [N-1:0]     i_req_InLow,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [PTR_W-1:0] o_grant,
    output logic             o_valid
);

    // One extra bit so ptr + offset cannot overflow before the modulo fold.
    logic [PTR_W:0] w_idx;

    always_comb begin
        o_valid = 1'b0;
        o_grant = '0;
        w_idx   = '0;
        for (int i = 0; i < N; i++) begin
            w_idx = {1'b0, i_ptr} + (PTR_W+1)'(i);
            if (w_idx >= (PTR_W+1)'(N)) begin
                w_idx = w_idx - (PTR_W+1)'(N);
            end
            if (!o_valid && !i_req_InLow[w_idx[PTR_W-1:0]]) begin
                o_valid = 1'b1;
                o_grant = w_idx[PTR_W-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sc_statemachine_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : sc_statemachine_ctrl
//  Description : Clear/load/upcount control FSM for the game datapath with
//                start gating, pause, round-robin load arbitration and a
//                speed-selectable tick divider pacing the upcount strobe.
//  Ports       : CLOCK_50          system clock
//                RESET_InLow       asynchronous active-low reset
//                startButton_InLow start/restart request (active low, level)
//                pause_InLow       pause request (active low, level)
//                T0_InLow          per-channel load requests (active low)
//                speed_In          tick period = TICK_PERIOD >> speed_In
//                clear_OutLow      datapath clear strobe (active low)
//                load_OutLow       per-channel load strobes (active low)
//                upcount_OutLow    counter increment strobe (active low)
//                running_OutHigh   high in CHECK_0/SHIFT_0/COUNT_0
//                state_Out         current state code
//  Revision    : 1.0 - initial release
// ============================================================================
module sc_statemachine_ctrl
    import sc_statemachine_ctrl_pkg::*;
#(
    parameter int CHANNELS    = 4,
    parameter int TICK_PERIOD = 64,
    parameter int TICK_W      = 16
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET_InLow,
    input  logic                 startButton_InLow,
    input  logic                 pause_InLow,
    input  logic [CHANNELS-1:0]  T0_InLow,
    input  logic [c_SPEED_W-1:0] speed_In,
    output logic                 clear_OutLow,
    output logic [CHANNELS-1:0]  load_OutLow,
    output logic                 upcount_OutLow,
    output logic                 running_OutHigh,
    output logic [c_STATE_W-1:0] state_Out
);

    localparam int c_PTR_W = $clog2(CHANNELS);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_PTR_W-1:0]  r_grant;
    logic [c_PTR_W-1:0]  r_rr_ptr;
    logic                r_last_was_shift;
    logic [TICK_W-1:0]   r_tick_cnt;
    logic                r_tick_pending;
    logic [c_PTR_W-1:0]  w_arb_grant;
    logic                w_arb_valid;
    logic [TICK_W-1:0]   w_tick_last;
    logic                w_running;
    logic                w_tick_wrap;

    sc_rr_arbiter #(
        .N     (CHANNELS),
        .PTR_W (c_PTR_W)
    ) u_arb (
        .i_req_InLow (T0_InLow),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_arb_grant),
        .o_valid     (w_arb_valid)
    );

    assign w_running   = (r_state == CHECK_0) || (r_state == SHIFT_0) ||
                         (r_state == COUNT_0);
    // Terminal count follows the currently selected speed at every compare.
    assign w_tick_last = (TICK_W'(TICK_PERIOD) >> speed_In) - TICK_W'(1);
    assign w_tick_wrap = w_running && (r_tick_cnt == w_tick_last);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RESET_0: w_state_nxt = START_0;
            START_0: w_state_nxt = IDLE_0;
            IDLE_0:  if (!startButton_InLow) w_state_nxt = INIT_0;
            INIT_0:  w_state_nxt = HOLD_0;
            // Waiting for release keeps one press from issuing repeated clears.
            HOLD_0:  if (startButton_InLow) w_state_nxt = CHECK_0;
            CHECK_0: begin
                if (!startButton_InLow) begin
                    w_state_nxt = INIT_0;
                end else if (!pause_InLow) begin
                    w_state_nxt = PAUSE_0;
                // A pending tick is serviced first right after a load, so a
                // permanently requesting channel cannot starve the counter.
                end else if (r_tick_pending && (r_last_was_shift || !w_arb_valid)) begin
                    w_state_nxt = COUNT_0;
                end else if (w_arb_valid) begin
                    w_state_nxt = SHIFT_0;
                end
            end
            SHIFT_0: w_state_nxt = CHECK_0;
            COUNT_0: w_state_nxt = CHECK_0;
            PAUSE_0: begin
                if (!startButton_InLow) begin
                    w_state_nxt = INIT_0;
                end else if (pause_InLow) begin
                    w_state_nxt = CHECK_0;
                end
            end
            default: w_state_nxt = IDLE_0;
        endcase
    end

    // ------------------------------------------------------------------
    // Moore output decode (state register only)
    // ------------------------------------------------------------------
    always_comb begin
        clear_OutLow    = 1'b1;
        load_OutLow     = '1;
        upcount_OutLow  = 1'b1;
        running_OutHigh = 1'b0;
        case (r_state)
            INIT_0:  clear_OutLow = 1'b0;
            CHECK_0: running_OutHigh = 1'b1;
            SHIFT_0: begin
                load_OutLow[r_grant] = 1'b0;
                running_OutHigh      = 1'b1;
            end
            COUNT_0: begin
                upcount_OutLow  = 1'b0;
                running_OutHigh = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_Out = r_state;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
        if (!RESET_InLow) begin
            r_state <= RESET_0;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Arbitration bookkeeping and tick divider
    // ------------------------------------------------------------------
    always_ff @(posedge CLOCK_50 or negedge RESET_InLow) begin
        if (!RESET_InLow) begin
            r_grant          <= '0;
            r_rr_ptr         <= '0;
            r_last_was_shift <= 1'b0;
            r_tick_cnt       <= '0;
            r_tick_pending   <= 1'b0;
        end else begin
            if ((r_state == CHECK_0) && (w_state_nxt == SHIFT_0)) begin
                r_grant <= w_arb_grant;
            end

            case (r_state)
                INIT_0: begin
                    r_rr_ptr         <= '0;
                    r_last_was_shift <= 1'b0;
                end
                SHIFT_0: begin
                    r_rr_ptr         <= (r_grant == c_PTR_W'(CHANNELS - 1)) ?
                                        '0 : r_grant + c_PTR_W'(1);
                    r_last_was_shift <= 1'b1;
                end
                COUNT_0: r_last_was_shift <= 1'b0;
                default: ;
            endcase

            if (r_state == INIT_0) begin
                r_tick_cnt     <= '0;
                r_tick_pending <= 1'b0;
            end else begin
                if (w_tick_wrap) begin
                    r_tick_cnt <= '0;
                end else if (w_running) begin
                    r_tick_cnt <= r_tick_cnt + TICK_W'(1);
                end
                // A wrap landing in COUNT_0 re-arms the tick just consumed.
                if (w_tick_wrap) begin
                    r_tick_pending <= 1'b1;
                end else if (r_state == COUNT_0) begin
                    r_tick_pending <= 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sc_statemachine_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sc_statemachine_ctrl
//  Description : Scoreboard bench for sc_statemachine_ctrl. A behavioural
//                model predicts the output vector for every clock; a monitor
//                compares the DUT against the queued predictions.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sc_statemachine_ctrl;

    localparam int CH = 4;
    localparam int TP = 8;
    localparam int TW = 16;

    logic          CLOCK_50          = 1'b0;
    logic          RESET_InLow       = 1'b0;
    logic          startButton_InLow = 1'b1;
    logic          pause_InLow       = 1'b1;
    logic [CH-1:0] T0_InLow          = '1;
    logic [1:0]    speed_In          = 2'd0;
    logic          clear_OutLow;
    logic [CH-1:0] load_OutLow;
    logic          upcount_OutLow;
    logic          running_OutHigh;
    logic [3:0]    state_Out;

    sc_statemachine_ctrl #(
        .CHANNELS    (CH),
        .TICK_PERIOD (TP),
        .TICK_W      (TW)
    ) dut (
        .CLOCK_50          (CLOCK_50),
        .RESET_InLow       (RESET_InLow),
        .startButton_InLow (startButton_InLow),
        .pause_InLow       (pause_InLow),
        .T0_InLow          (T0_InLow),
        .speed_In          (speed_In),
        .clear_OutLow      (clear_OutLow),
        .load_OutLow       (load_OutLow),
        .upcount_OutLow    (upcount_OutLow),
        .running_OutHigh   (running_OutHigh),
        .state_Out         (state_Out)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct packed {
        logic [3:0]    st;
        logic          clr;
        logic [CH-1:0] ld;
        logic          up;
        logic          run;
    } exp_t;

    exp_t exp_q[$];
    exp_t m_e;
    exp_t m_a;
    int   checks = 0;
    int   errors = 0;

    // ---------------- behavioural reference model -----------------------
    // Phase numbers are the published state codes; 5/6/7 are the running
    // phases (check, load, count), 3 is the clear phase.
    int m_state = 0, m_cnt = 0, m_ptr = 0, m_grant = 0;
    bit m_pend = 0, m_lws = 0;

    function automatic int pick(input logic [CH-1:0] t0, input int ptr);
        for (int k = 0; k < CH; k++) begin
            int c;
            c = (ptr + k) % CH;
            if (!t0[c]) return c;
        end
        return 0;
    endfunction

    task automatic model_step(input bit rst_n, input bit st_n, input bit pa_n,
                              input logic [CH-1:0] t0, input logic [1:0] spd);
        int ns, ncnt, nptr, ngrant, period;
        bit npend, nlws, any_req, run;
        if (!rst_n) begin
            m_state = 0; m_cnt = 0; m_pend = 0; m_ptr = 0; m_lws = 0; m_grant = 0;
            return;
        end
        any_req = (t0 != '1);
        run     = (m_state >= 5 && m_state <= 7);
        ns = m_state; ncnt = m_cnt; npend = m_pend; nptr = m_ptr;
        nlws = m_lws; ngrant = m_grant;
        period = TP >> spd;
        if (m_state == 3) begin
            ncnt = 0; npend = 0;
        end else if (run) begin
            if (m_cnt == period - 1) begin
                ncnt = 0; npend = 1;
            end else begin
                ncnt = (m_cnt + 1) % (1 << TW);
                if (m_state == 7) npend = 0;
            end
        end
        case (m_state)
            0: ns = 1;
            1: ns = 2;
            2: if (!st_n) ns = 3;
            3: begin ns = 4; nptr = 0; nlws = 0; end
            4: if (st_n) ns = 5;
            5: begin
                if (!st_n) ns = 3;
                else if (!pa_n) ns = 8;
                else if (m_pend && (m_lws || !any_req)) ns = 7;
                else if (any_req) begin ns = 6; ngrant = pick(t0, m_ptr); end
            end
            6: begin ns = 5; nptr = (m_grant + 1) % CH; nlws = 1; end
            7: begin ns = 5; nlws = 0; end
            8: begin
                if (!st_n) ns = 3;
                else if (pa_n) ns = 5;
            end
            default: ns = 2;
        endcase
        m_state = ns; m_cnt = ncnt; m_pend = npend; m_ptr = nptr;
        m_lws = nlws; m_grant = ngrant;
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        e.st  = 4'(m_state);
        e.clr = (m_state != 3);
        e.ld  = '1;
        if (m_state == 6) e.ld[m_grant] = 1'b0;
        e.up  = (m_state != 7);
        e.run = (m_state >= 5 && m_state <= 7);
        return e;
    endfunction

    // ---------------- stimulus helpers ----------------------------------
    task automatic cyc(input bit r, input bit s, input bit p,
                       input logic [CH-1:0] t, input logic [1:0] sp);
        @(negedge CLOCK_50);
        RESET_InLow       = r;
        startButton_InLow = s;
        pause_InLow       = p;
        T0_InLow          = t;
        speed_In          = sp;
        model_step(r, s, p, t, sp);
        exp_q.push_back(expect_now());
    endtask

    task automatic settle();
        @(posedge CLOCK_50);
        #2;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Only change speed when the tick count is 0 so a faster rate never
    // starts above its terminal count.
    task automatic go_speed(input logic [1:0] sp, input logic [CH-1:0] t);
        int n;
        n = 0;
        while (m_cnt != 0 && n < 100) begin
            cyc(1, 1, 1, t, speed_In);
            n++;
        end
        if (m_cnt != 0) chk("speed_switch_timeout", m_cnt, 0);
        cyc(1, 1, 1, t, sp);
    endtask

    // ---------------- monitor -------------------------------------------
    int cyc_n = 0, clr_pulses = 0, last_up = -1, up_gap = 0;
    int grant_log[$];

    always begin
        @(posedge CLOCK_50);
        #1;
        cyc_n++;
        if (!clear_OutLow) clr_pulses++;
        if (!upcount_OutLow) begin
            if (last_up >= 0) up_gap = cyc_n - last_up;
            last_up = cyc_n;
        end
        if (load_OutLow != '1) begin
            for (int b = 0; b < CH; b++) begin
                if (!load_OutLow[b]) grant_log.push_back(b);
            end
        end
        if (exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            m_a = {state_Out, clear_OutLow, load_OutLow, upcount_OutLow, running_OutHigh};
            checks++;
            if (m_a !== m_e) begin
                errors++;
                $display("FAIL scoreboard cyc %0d: got st=%0d clr=%b ld=%b up=%b run=%b, expected st=%0d clr=%b ld=%b up=%b run=%b",
                         cyc_n, m_a.st, m_a.clr, m_a.ld, m_a.up, m_a.run,
                         m_e.st, m_e.clr, m_e.ld, m_e.up, m_e.run);
            end
        end
    end

    // ---------------- stimulus ------------------------------------------
    initial begin
        int c0, n;
        bit ok;
        logic [1:0] sp;
        bit r, s, p;

        // reset, release, idle
        repeat (3) cyc(0, 1, 1, '1, 2'd0);
        repeat (6) cyc(1, 1, 1, '1, 2'd0);

        // one long press -> exactly one clear
        c0 = clr_pulses;
        repeat (5) cyc(1, 0, 1, '1, 2'd0);
        cyc(1, 1, 1, '1, 2'd0);
        settle();
        chk("single_clear_per_press", clr_pulses - c0, 1);

        // slowest tick rate, no loads
        repeat (40) cyc(1, 1, 1, '1, 2'd0);
        settle();
        chk("upcount_gap_speed0", up_gap, 8);

        // fastest tick rate
        go_speed(2'd2, '1);
        repeat (20) cyc(1, 1, 1, '1, 2'd2);
        settle();
        chk("upcount_gap_speed2", up_gap, 2);

        // round robin with every channel requesting
        grant_log.delete();
        repeat (30) cyc(1, 1, 1, 4'b0000, 2'd2);
        settle();
        ok = (grant_log.size() >= 5);
        for (int k = 1; k < grant_log.size(); k++) begin
            if (grant_log[k] != (grant_log[k-1] + 1) % CH) ok = 0;
        end
        chk("rr_sequence", int'(ok), 1);

        // pause at tick count 5
        go_speed(2'd0, '1);
        n = 0;
        while (!(m_state == 5 && m_cnt == 5) && n < 60) begin
            cyc(1, 1, 1, '1, 2'd0);
            n++;
        end
        chk("reach_tick5", m_cnt, 5);
        repeat (20) cyc(1, 1, 0, '1, 2'd0);
        repeat (15) cyc(1, 1, 1, '1, 2'd0);

        // restart from pause, then channel 0 should win with ptr back at 0
        repeat (3) cyc(1, 1, 0, '1, 2'd0);
        repeat (2) cyc(1, 0, 0, '1, 2'd0);
        grant_log.delete();
        repeat (4) cyc(1, 1, 1, 4'b1100, 2'd0);
        settle();
        chk("restart_grant_count_nonzero", int'(grant_log.size() > 0), 1);
        if (grant_log.size() > 0) chk("restart_first_grant", grant_log[0], 0);

        // randomized traffic
        sp = 2'd0;
        for (int i = 0; i < 1500; i++) begin
            r = ($urandom_range(0, 999) != 0);
            s = ($urandom_range(0, 99) >= 4);
            p = ($urandom_range(0, 99) >= 8);
            if (m_cnt == 0 && $urandom_range(0, 9) == 0) sp = 2'($urandom_range(0, 3));
            cyc(r, s, p, CH'($urandom), sp);
        end

        // asynchronous reset during COUNT_0
        go_speed(2'd2, '1);
        repeat (2) cyc(1, 0, 1, '1, 2'd2);
        n = 0;
        while (m_state != 7 && n < 100) begin
            cyc(1, 1, 1, '1, 2'd2);
            n++;
        end
        chk("reach_count_state", m_state, 7);
        @(posedge CLOCK_50);
        #3;
        chk("upcount_before_reset", int'(upcount_OutLow), 0);
        RESET_InLow = 1'b0;
        #1;
        chk("async_reset_state", int'(state_Out), 0);
        chk("async_reset_upcount", int'(upcount_OutLow), 1);
        chk("async_reset_running", int'(running_OutHigh), 0);
        repeat (2) cyc(0, 1, 1, '1, 2'd0);
        repeat (4) cyc(1, 1, 1, '1, 2'd0);
        settle();
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
